// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the 8x8 RGB matrix scanner.
// Pixels are active-low: 0 lights the LED.
package matrix_pkg;

  typedef logic [7:0] row_t;

  typedef struct packed {
    row_t r;
    row_t g;
    row_t b;
  } rgb_row_t;

  localparam int         MATRIX_ROWS = 8;
  localparam logic [3:0] SEL_BASE    = 4'b1000;
  localparam row_t       PIXEL_OFF   = 8'hFF;

  localparam rgb_row_t RGB_OFF = '{
    r: PIXEL_OFF,
    g: PIXEL_OFF,
    b: PIXEL_OFF
  };

  typedef enum logic {
    SCAN,
    SWAP_WAIT
  } scan_state_e;

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Writer-side bus of the matrix frame store.
// master = game core, slave = scanner.
interface led_matrix_scanner_if;
  import matrix_pkg::*;

  logic       WR_EN;
  logic [2:0] WR_ROW;
  row_t       WR_R;
  row_t       WR_G;
  row_t       WR_B;
  logic       WR_READY;
  logic       SWAP_REQ;
  logic       SWAP_DONE;

  modport master (
    output WR_EN, WR_ROW,
    output WR_R, WR_G, WR_B,
    output SWAP_REQ,
    input  WR_READY, SWAP_DONE
  );

  modport slave (
    input  WR_EN, WR_ROW,
    input  WR_R, WR_G, WR_B,
    input  SWAP_REQ,
    output WR_READY, SWAP_DONE
  );

endinterface

// File: rtl/led_matrix_scanner_frame_buf.sv
// Double-buffered frame store: writes hit the back bank,
// reads are combinational from the selected bank.
module matrix_frame_buf
  import matrix_pkg::*;
(
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     front_sel,
  input  logic     wr_en,
  input  logic [2:0] wr_row,
  input  rgb_row_t wr_data,
  input  logic     rd_sel,
  input  logic [2:0] rd_row,
  output rgb_row_t rd_data
);

  rgb_row_t bank0 [MATRIX_ROWS];
  rgb_row_t bank1 [MATRIX_ROWS];

  // Back-bank row write; reset blanks both banks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < MATRIX_ROWS; i++) begin
        bank0[i] <= RGB_OFF;
        bank1[i] <= RGB_OFF;
      end
    end else if (wr_en) begin
      if (front_sel)
        bank0[wr_row] <= wr_data;
      else
        bank1[wr_row] <= wr_data;
    end
  end

  assign rd_data = rd_sel ? bank1[rd_row]
                          : bank0[rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scanner for the 8x8 RGB matrix.
// Optional MATRIX_BLANK_EN blanks the first BLANK_CYCLES of each row.
module led_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST_N,
  led_matrix_scanner_if.slave wr_bus,
  output row_t DATA_R,
  output row_t DATA_G,
  output row_t DATA_B,
  output logic [3:0] SEL,
  output logic ROW_STROBE
);

  localparam int CW = $clog2(DWELL_CYCLES);

  if (DWELL_CYCLES < 2 ||
      BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_cfg
    $error("invalid DWELL/BLANK configuration");
  end

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic          front_q, front_d;
  logic          done_d, done_q;
  logic          strobe_q;
  logic [3:0]    sel_q;
  rgb_row_t      data_q, pix, rd_rgb, wr_rgb;
  logic          tc, boundary, wr_acc;
  logic          byp, blank_d;

  assign tc       = cnt_q == CW'(DWELL_CYCLES - 1);
  assign boundary = tc && row_q == 3'd7;
  assign wr_acc   = wr_bus.WR_EN && state_q == SCAN;
  assign cnt_d    = tc ? '0 : cnt_q + 1'b1;
  assign row_d    = tc ? row_q + 3'd1 : row_q;

  assign wr_rgb = '{
    r: wr_bus.WR_R,
    g: wr_bus.WR_G,
    b: wr_bus.WR_B
  };

  matrix_frame_buf u_buf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .front_sel (front_q),
    .wr_en     (wr_acc),
    .wr_row    (wr_bus.WR_ROW),
    .wr_data   (wr_rgb),
    .rd_sel    (front_d),
    .rd_row    (row_d),
    .rd_data   (rd_rgb)
  );

  // Swap control: latch a request, flip banks at frame end.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    done_d  = 1'b0;
    unique case (state_q)
      SCAN:
        if (wr_bus.SWAP_REQ) state_d = SWAP_WAIT;
      SWAP_WAIT:
        state_d = SWAP_WAIT;
      default:
        state_d = SCAN;
    endcase
    if (boundary && state_d == SWAP_WAIT) begin
      state_d = SCAN;
      front_d = !front_q;
      done_d  = 1'b1;
    end
  end

  // A write landing on the swap edge is already the new front.
  assign byp = wr_acc && (front_d != front_q) &&
               wr_bus.WR_ROW == row_d;
  assign pix = byp ? wr_rgb : rd_rgb;

`ifdef MATRIX_BLANK_EN
  assign blank_d = cnt_d < CW'(BLANK_CYCLES);
`else
  assign blank_d = 1'b0;
`endif

  // Scan counters, swap state and registered pin drive.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      row_q    <= '0;
      front_q  <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      sel_q    <= SEL_BASE;
      data_q   <= RGB_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      front_q  <= front_d;
      done_q   <= done_d;
      strobe_q <= tc;
      sel_q    <= SEL_BASE | {1'b0, row_d};
      data_q   <= blank_d ? RGB_OFF : pix;
    end
  end

  assign wr_bus.WR_READY  = state_q == SCAN;
  assign wr_bus.SWAP_DONE = done_q;
  assign SEL        = sel_q;
  assign ROW_STROBE = strobe_q;
  assign DATA_R     = data_q.r;
  assign DATA_G     = data_q.g;
  assign DATA_B     = data_q.b;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner, DWELL=4, BLANK=1.
// Honours MATRIX_BLANK_EN when the build defines it.
module tb_led_matrix_scanner;
  import matrix_pkg::*;

  typedef struct {
    logic [3:0] esel;
    logic       estb;
    row_t       edata;
  } scan_vec_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  row_t DATA_R, DATA_G, DATA_B;
  logic [3:0] SEL;
  logic ROW_STROBE;

  int ntests = 0;
  int nfail  = 0;
  int kcyc   = 0;
  logic front_b = 1'b0;
  rgb_row_t img_a [8];
  rgb_row_t img_b [8];
  scan_vec_t tbl [40];

  led_matrix_scanner_if bus ();

  led_matrix_scanner #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wr_bus     (bus.slave),
    .DATA_R     (DATA_R),
    .DATA_G     (DATA_G),
    .DATA_B     (DATA_B),
    .SEL        (SEL),
    .ROW_STROBE (ROW_STROBE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic we,
                       input logic [2:0] wrow,
                       input row_t r, input row_t g,
                       input row_t b, input logic sw);
    bus.WR_EN    = we;
    bus.WR_ROW   = wrow;
    bus.WR_R     = r;
    bus.WR_G     = g;
    bus.WR_B     = b;
    bus.SWAP_REQ = sw;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic clear_imgs();
    for (int i = 0; i < 8; i++) begin
      img_a[i] = RGB_OFF;
      img_b[i] = RGB_OFF;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sel"}, 32'(SEL), 32'h8);
    chk({tag, " r"}, 32'(DATA_R), 32'hFF);
    chk({tag, " g"}, 32'(DATA_G), 32'hFF);
    chk({tag, " b"}, 32'(DATA_B), 32'hFF);
    chk({tag, " ready"}, 32'(bus.WR_READY), 32'h1);
    chk({tag, " done"}, 32'(bus.SWAP_DONE), 32'h0);
    chk({tag, " strobe"}, 32'(ROW_STROBE), 32'h0);
  endtask

  // One clock, then compare every output with the frame model.
  task automatic tick(input logic ed, input logic er);
    rgb_row_t e;
    int row;
    int cnt;
    string t;
    @(posedge CLK);
    #1;
    kcyc++;
    row = (kcyc / 4) % 8;
    cnt = kcyc % 4;
    e = front_b ? img_b[row] : img_a[row];
`ifdef MATRIX_BLANK_EN
    if (cnt < 1) e = RGB_OFF;
`endif
    t = $sformatf("k%0d", kcyc);
    chk({t, " sel"}, 32'(SEL), 32'(8 + row));
    chk({t, " strobe"}, 32'(ROW_STROBE),
        32'(cnt == 0));
    chk({t, " r"}, 32'(DATA_R), 32'(e.r));
    chk({t, " g"}, 32'(DATA_G), 32'(e.g));
    chk({t, " b"}, 32'(DATA_B), 32'(e.b));
    chk({t, " done"}, 32'(bus.SWAP_DONE), 32'(ed));
    chk({t, " ready"}, 32'(bus.WR_READY), 32'(er));
  endtask

  initial begin
    idle();
    clear_imgs();
    for (int i = 0; i < 40; i++) begin
      tbl[i].esel  = 4'(8 + ((i + 1) / 4) % 8);
      tbl[i].estb  = ((i + 1) % 4) == 0;
      tbl[i].edata = 8'hFF;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    kcyc  = 0;

    // Idle scan, table driven
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      kcyc++;
      chk($sformatf("tbl%0d sel", i),
          32'(SEL), 32'(tbl[i].esel));
      chk($sformatf("tbl%0d strobe", i),
          32'(ROW_STROBE), 32'(tbl[i].estb));
      chk($sformatf("tbl%0d r", i),
          32'(DATA_R), 32'(tbl[i].edata));
      chk($sformatf("tbl%0d g", i),
          32'(DATA_G), 32'(tbl[i].edata));
      chk($sformatf("tbl%0d b", i),
          32'(DATA_B), 32'(tbl[i].edata));
    end

    // Write rows 3 and 2, swap request with second write
    drive(1'b1, 3'd3, 8'hFF, 8'hE7, 8'hFF, 1'b0);
    img_b[3].g = 8'hE7;
    tick(1'b0, 1'b1);
    drive(1'b1, 3'd2, 8'hFF, 8'hFF, 8'h0F, 1'b1);
    img_b[2].b = 8'h0F;
    tick(1'b0, 1'b0);
    idle();
    while (kcyc < 63) tick(1'b0, 1'b0);
    front_b = 1'b1;
    tick(1'b1, 1'b1);
    while (kcyc < 96) tick(1'b0, 1'b1);

    // Dropped write and repeated request while pending
    drive(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    tick(1'b0, 1'b0);
    drive(1'b1, 3'd0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    tick(1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    tick(1'b0, 1'b0);
    idle();
    while (kcyc < 127) tick(1'b0, 1'b0);
    front_b = 1'b0;
    tick(1'b1, 1'b1);
    while (kcyc < 159) tick(1'b0, 1'b1);

    // Request and write on the frame-boundary cycle
    drive(1'b1, 3'd0, 8'hFF, 8'h3C, 8'hFF, 1'b1);
    img_b[0].g = 8'h3C;
    front_b = 1'b1;
    tick(1'b1, 1'b1);
    idle();
    while (kcyc < 192) tick(1'b0, 1'b1);

    // Reset mid row 5 while a swap is pending
    drive(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    tick(1'b0, 1'b0);
    idle();
    while (kcyc < 214) tick(1'b0, 1'b0);
    RST_N = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    kcyc = 0;
    front_b = 1'b0;
    clear_imgs();
    while (kcyc < 40) tick(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
